// File: rtl/riscv_dmem_pkg.sv
// Shared types and constants for the LSU-side data memory controller.
// Optional build macro: RISCV_DMEM_BOUNDS_EN (address range check).
package riscv_dmem_pkg;

  localparam int BE_W    = 4;
  localparam int WORD_W  = 32;
  localparam int CNT_W   = 4;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 15;

  localparam logic [WORD_W-1:0] OOR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

endpackage

// File: rtl/riscv_dmem_if.sv
// LSU memory port: request fields from the initiator, rd/ready back.
// Optional build macro: RISCV_DMEM_BOUNDS_EN adds the sticky oor flag.
interface riscv_dmem_if;
  import riscv_dmem_pkg::*;

  logic              req;
  logic              we;
  logic [BE_W-1:0]   be;
  logic [31:0]       addr;
  logic [WORD_W-1:0] wd;
  logic [WORD_W-1:0] rd;
  logic              ready;
`ifdef RISCV_DMEM_BOUNDS_EN
  logic              oor;
`endif

  modport master (
    output req, we, be, addr, wd,
`ifdef RISCV_DMEM_BOUNDS_EN
    input  oor,
`endif
    input  rd, ready
  );

  modport slave (
    input  req, we, be, addr, wd,
`ifdef RISCV_DMEM_BOUNDS_EN
    output oor,
`endif
    output rd, ready
  );

endinterface

// File: rtl/riscv_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read.
// Optional build macro: RISCV_DMEM_BOUNDS_EN (unused here).
module riscv_dmem_ram
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [BE_W-1:0]   wen,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] ram [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int k = 0; k < BE_W; k++) begin
      if (wen[k]) ram[addr][8*k +: 8] <= wdata[8*k +: 8];
    end
  end

  // Read register doubles as the hold register for the last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (rd_en) rdata <= ram[addr];
  end

endmodule

// File: rtl/riscv_dmem_ctrl.sv
// Fixed-latency data memory responder for the LSU bus.
// Optional build macro: RISCV_DMEM_BOUNDS_EN (range check, oor flag).
module riscv_dmem_ctrl
  import riscv_dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic         clk_i,
  input logic         rst_ni,
  riscv_dmem_if.slave mem
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LD = CNT_W'(LATENCY - 1);

  dmem_state_t       state, nxt;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              we_q;
  logic [BE_W-1:0]   be_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wd_q;
  logic [31:0]       cur_addr;
  logic [31:0]       off;
  logic              cur_we;
  logic              ok;
  logic              rd_en;
  logic [BE_W-1:0]   wen;
  logic [AW-1:0]     idx;
  logic [WORD_W-1:0] ram_q;
  logic              unused_off;

  // In IDLE the live request addresses the RAM (LATENCY=1 reads).
  assign cur_addr = (state == IDLE) ? mem.addr : addr_q;
  assign cur_we   = (state == IDLE) ? mem.we : we_q;
  assign off      = cur_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign unused_off = ^off;

`ifdef RISCV_DMEM_BOUNDS_EN
  assign ok = (off[31:2] < 30'(DEPTH_WORDS));
`else
  assign ok = 1'b1;
`endif

  always_comb begin
    nxt   = state;
    cnt_d = cnt;
    unique case (state)
      IDLE: begin
        if (mem.req) begin
          cnt_d = CNT_LD;
          nxt   = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt - 1'b1;
        if (cnt <= 1) nxt = RESP;
      end
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      be_q   <= '0;
      addr_q <= '0;
      wd_q   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_d;
      if (state == IDLE && mem.req) begin
        we_q   <= mem.we;
        be_q   <= mem.be;
        addr_q <= mem.addr;
        wd_q   <= mem.wd;
      end
    end
  end

  assign rd_en     = (nxt == RESP) && !cur_we;
  assign wen       = (state == RESP && we_q && ok) ? be_q : '0;
  assign mem.ready = (state == RESP);

  riscv_dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .rd_en (rd_en),
    .wen   (wen),
    .addr  (idx),
    .wdata (wd_q),
    .rdata (ram_q)
  );

`ifdef RISCV_DMEM_BOUNDS_EN
  logic oor_rd;
  logic oor_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      oor_rd <= 1'b0;
      oor_q  <= 1'b0;
    end else begin
      if (rd_en) oor_rd <= !ok;
      if (nxt == RESP && !ok) oor_q <= 1'b1;
    end
  end

  assign mem.rd  = oor_rd ? OOR_RDATA : ram_q;
  assign mem.oor = oor_q;
`else
  assign mem.rd = ram_q;
`endif

endmodule

// File: tb/tb_riscv_dmem_ctrl.sv
// Directed scoreboard bench for riscv_dmem_ctrl (LATENCY 2 plus 1/4/15).
// Optional build macro: RISCV_DMEM_BOUNDS_EN selects the bounds checks.
module tb_riscv_dmem_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   ntests = 0;
  int   nfail  = 0;

  logic [31:0] sb [$];
  logic [31:0] mdl [1024];
  logic [31:0] last_rd;

  riscv_dmem_if bus2 ();
  riscv_dmem_if bus1 ();
  riscv_dmem_if bus4 ();
  riscv_dmem_if bus15 ();

  riscv_dmem_ctrl #(.LATENCY(2)) u2 (
    .clk_i (clk), .rst_ni (rst_n), .mem (bus2)
  );
  riscv_dmem_ctrl #(.LATENCY(1)) u1 (
    .clk_i (clk), .rst_ni (rst_n), .mem (bus1)
  );
  riscv_dmem_ctrl #(.LATENCY(4)) u4 (
    .clk_i (clk), .rst_ni (rst_n), .mem (bus4)
  );
  riscv_dmem_ctrl #(.LATENCY(15)) u15 (
    .clk_i (clk), .rst_ni (rst_n), .mem (bus15)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [31:0] a);
`ifdef RISCV_DMEM_BOUNDS_EN
    if (a >= 32'h1000) return 32'hDEAD_BEEF;
`endif
    return mdl[a[11:2]];
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [3:0] b,
                           input logic [31:0] d);
`ifdef RISCV_DMEM_BOUNDS_EN
    if (a >= 32'h1000) return;
`endif
    for (int k = 0; k < 4; k++)
      if (b[k]) mdl[a[11:2]][8*k +: 8] = d[8*k +: 8];
  endtask

  task automatic access(input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
    int n;
    logic [31:0] e;
    @(negedge clk);
    bus2.req  = 1'b1;
    bus2.we   = w;
    bus2.be   = b;
    bus2.addr = a;
    bus2.wd   = d;
    if (!w) sb.push_back(exp_read(a));
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus2.ready && n < 20);
    chk("latency", n, 2);
    bus2.req = 1'b0;
    if (!w) begin
      e = sb.pop_front();
      if (bus2.ready) chk("rdata", bus2.rd, e);
      last_rd = e;
    end else begin
      if (bus2.ready) chk("wr_rd_hold", bus2.rd, last_rd);
      mdl_write(a, b, d);
    end
    @(negedge clk);
    chk("ready_one_cycle", bus2.ready, 0);
  endtask

  initial begin
    int lat [3];
    int cnt [3];
    int last [3];
    logic prev [3];
    logic [2:0] rdy;

    lat = '{1, 4, 15};
    rst_n = 1'b0;
    last_rd = '0;
    bus2.req = 0; bus2.we = 0; bus2.be = 0; bus2.addr = 0; bus2.wd = 0;
    bus1.req = 0; bus1.we = 0; bus1.be = 0; bus1.addr = 0; bus1.wd = 0;
    bus4.req = 0; bus4.we = 0; bus4.be = 0; bus4.addr = 0; bus4.wd = 0;
    bus15.req = 0; bus15.we = 0; bus15.be = 0; bus15.addr = 0;
    bus15.wd = 0;

    repeat (3) begin
      @(negedge clk);
      chk("rst_ready", bus2.ready, 0);
      chk("rst_rd", bus2.rd, 0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("idle_ready", bus2.ready, 0);
      chk("idle_rd", bus2.rd, 0);
    end
`ifdef RISCV_DMEM_BOUNDS_EN
    chk("idle_oor", bus2.oor, 0);
`endif

    access(1'b1, 4'hF, 32'h10, 32'h1234_5678);
    access(1'b0, 4'hF, 32'h10, 32'h0);

    access(1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
    access(1'b1, 4'b0100, 32'h20, 32'h5555_5555);
    access(1'b0, 4'hF, 32'h20, 32'h0);
    chk("lane2_value", last_rd, 32'hAA55_CCDD);
    access(1'b1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
    access(1'b0, 4'hF, 32'h20, 32'h0);
    chk("be0_unchanged", last_rd, 32'hAA55_CCDD);

    access(1'b1, 4'hF, 32'h0, 32'h0BAD_F00D);
    access(1'b0, 4'hF, 32'h1000, 32'h0);
`ifdef RISCV_DMEM_BOUNDS_EN
    chk("oor_set", bus2.oor, 1);
`else
    chk("wrap_read", last_rd, 32'h0BAD_F00D);
`endif
    access(1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
    access(1'b0, 4'hF, 32'h0, 32'h0);
`ifdef RISCV_DMEM_BOUNDS_EN
    chk("oor_drop", last_rd, 32'h0BAD_F00D);
    chk("oor_sticky", bus2.oor, 1);
`endif

    access(1'b1, 4'hF, 32'h40, 32'h1111_2222);
    @(negedge clk);
    bus2.req  = 1'b1;
    bus2.we   = 1'b1;
    bus2.be   = 4'hF;
    bus2.addr = 32'h40;
    bus2.wd   = 32'hCAFE_F00D;
    @(posedge clk);
    @(negedge clk);
    chk("wait_ready", bus2.ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", bus2.ready, 0);
    chk("midrst_rd", bus2.rd, 0);
`ifdef RISCV_DMEM_BOUNDS_EN
    chk("midrst_oor", bus2.oor, 0);
`endif
    bus2.req = 1'b0;
    last_rd = '0;
    @(negedge clk);
    chk("midrst_hold", bus2.ready, 0);
    rst_n = 1'b1;
    access(1'b0, 4'hF, 32'h40, 32'h0);
    chk("abandoned_wr", last_rd, 32'h1111_2222);

    for (int d = 0; d < 3; d++) begin
      cnt[d] = 0;
      last[d] = 0;
      prev[d] = 1'b0;
    end
    @(negedge clk);
    bus1.req = 1'b1;
    bus4.req = 1'b1;
    bus15.req = 1'b1;
    bus1.be = 4'hF;
    bus4.be = 4'hF;
    bus15.be = 4'hF;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rdy = {bus15.ready, bus4.ready, bus1.ready};
      for (int d = 0; d < 3; d++) begin
        if (rdy[d] && cnt[d] < 20) begin
          if (cnt[d] > 0) chk("spacing", cyc - last[d], lat[d] + 1);
          chk("no_b2b", prev[d], 0);
          last[d] = cyc;
          cnt[d]++;
        end
        prev[d] = rdy[d];
      end
      if (cnt[0] >= 20 && cnt[1] >= 20 && cnt[2] >= 20) break;
    end
    bus1.req = 1'b0;
    bus4.req = 1'b0;
    bus15.req = 1'b0;
    for (int d = 0; d < 3; d++) chk("sweep_count", cnt[d], 20);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
